// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared state encodings and stall-cause constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam int DEF_REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MC_WAIT  = 2'd2
  } state_t;

  // One-hot stall cause: {mem, mc, loaduse}
  localparam logic [2:0] STALL_NONE = 3'b000;
  localparam logic [2:0] STALL_MEM  = 3'b100;
  localparam logic [2:0] STALL_MC   = 3'b010;
  localparam logic [2:0] STALL_LU   = 3'b001;

endpackage

// File: rtl/pipe_hazard_ctrl_loaduse_det.sv
// Combinational load-use comparator: a load in EX whose destination is read by ID.
module hazard_loaduse_det
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic                      rs1_used,
  input  logic                      rs2_used,
  input  logic                      ex_valid,
  input  logic                      ex_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      hazard
);

  // x0 is hardwired to zero, so a load into it never creates a dependency
  assign hazard = ex_valid && ex_is_load && (ex_rd != '0) &&
                  ((rs1_used && (rs1_addr == ex_rd)) ||
                   (rs2_used && (rs2_addr == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline with multi-cycle watchdog.
// Optional perf counters are enabled with the PIPE_CTRL_PERF_EN macro.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int MC_TIMEOUT     = 64
`ifdef PIPE_CTRL_PERF_EN
  , parameter int PERF_CNT_W   = 32
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic                      ex_valid,
  input  logic                      ex_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_mc_req,
  input  logic                      mc_done,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  input  logic                      redirect_valid,
  output logic                      pc_en,
  output logic                      if_id_en,
  output logic                      if_id_flush,
  output logic                      id_ex_en,
  output logic                      id_ex_flush,
  output logic                      ex_mem_en,
  output logic                      mem_wb_en,
  output logic [2:0]                stall_cause,
  output logic                      mc_timeout
`ifdef PIPE_CTRL_PERF_EN
  , output logic [PERF_CNT_W-1:0]   perf_stall_mem
  , output logic [PERF_CNT_W-1:0]   perf_stall_mc
  , output logic [PERF_CNT_W-1:0]   perf_stall_lu
  , output logic [PERF_CNT_W-1:0]   perf_flush
`endif
);

  localparam int CNT_W = $clog2(MC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MC_TIMEOUT);

  state_t state, next_state;
  logic [CNT_W-1:0] mc_cnt, next_cnt;
  logic redirect_pend;
  logic lu_hazard, mem_stall, mc_stall, mc_expire, redirect_any;

  hazard_loaduse_det #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_loaduse (
    .rs1_addr   (id_rs1_addr),
    .rs2_addr   (id_rs2_addr),
    .rs1_used   (id_rs1_used),
    .rs2_used   (id_rs2_used),
    .ex_valid   (ex_valid),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .hazard     (lu_hazard)
  );

  assign mem_stall    = mem_req && !mem_ready;
  assign redirect_any = redirect_valid || redirect_pend;
  assign mc_expire    = (state == ST_MC_WAIT) && !mc_done && (mc_cnt == TIMEOUT_VAL);

  // Once waiting, the op is tracked by the counter rather than the EX level
  always_comb begin
    mc_stall = 1'b0;
    if (state == ST_MC_WAIT) mc_stall = !mc_done && (mc_cnt != TIMEOUT_VAL);
    else                     mc_stall = ex_valid && ex_mc_req && !mc_done;
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    stall_cause = STALL_NONE;
    next_state  = ST_RUN;
    next_cnt    = '0;
    if (rst_n) begin
      if (mem_stall) begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
        stall_cause = STALL_MEM;
        if ((state == ST_MC_WAIT) && mc_stall) begin
          next_state = ST_MC_WAIT;
          next_cnt   = mc_cnt + 1'b1;
        end else begin
          next_state = ST_MEM_WAIT;
        end
      end else if (mc_stall) begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en} = '0;
        stall_cause = STALL_MC;
        next_state  = ST_MC_WAIT;
        next_cnt    = (state == ST_MC_WAIT) ? mc_cnt + 1'b1 : CNT_W'(1);
      end else if (redirect_any) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu_hazard) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
        stall_cause = STALL_LU;
      end
    end
  end

  // A redirect seen while stalled is held until the first free cycle flushes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_RUN;
      mc_cnt        <= '0;
      redirect_pend <= 1'b0;
      mc_timeout    <= 1'b0;
    end else begin
      state  <= next_state;
      mc_cnt <= next_cnt;
      if (mc_expire) mc_timeout <= 1'b1;
      if (mem_stall || mc_stall) begin
        if (redirect_valid) redirect_pend <= 1'b1;
      end else begin
        redirect_pend <= 1'b0;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [PERF_CNT_W-1:0] PERF_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_mem <= '0;
      perf_stall_mc  <= '0;
      perf_stall_lu  <= '0;
      perf_flush     <= '0;
    end else begin
      if (stall_cause[2] && (perf_stall_mem != PERF_MAX)) perf_stall_mem <= perf_stall_mem + 1'b1;
      if (stall_cause[1] && (perf_stall_mc  != PERF_MAX)) perf_stall_mc  <= perf_stall_mc + 1'b1;
      if (stall_cause[0] && (perf_stall_lu  != PERF_MAX)) perf_stall_lu  <= perf_stall_lu + 1'b1;
      if (if_id_flush    && (perf_flush     != PERF_MAX)) perf_flush     <= perf_flush + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic
// against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;
  localparam int TO = 64;
  localparam int PW = 32;

  localparam int K_NONE  = 0;
  localparam int K_MEM   = 1;
  localparam int K_MC    = 2;
  localparam int K_REDIR = 3;
  localparam int K_LU    = 4;
  localparam int K_RESET = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_valid, ex_is_load, ex_mc_req, mc_done;
  logic mem_req, mem_ready, redirect_valid;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic [2:0] stall_cause;
  logic mc_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [PW-1:0] perf_stall_mem, perf_stall_mc, perf_stall_lu, perf_flush;
`endif

  int checks = 0;
  int failures = 0;

  // reference model state
  int mc_age = 0;
  bit pend = 0;
  bit tflag = 0;
  int cnt_mem = 0, cnt_mc = 0, cnt_lu = 0, cnt_fl = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_ADDR_WIDTH (AW),
    .MC_TIMEOUT     (TO)
`ifdef PIPE_CTRL_PERF_EN
    , .PERF_CNT_W   (PW)
`endif
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .ex_valid       (ex_valid),
    .ex_is_load     (ex_is_load),
    .ex_rd          (ex_rd),
    .ex_mc_req      (ex_mc_req),
    .mc_done        (mc_done),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .redirect_valid (redirect_valid),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .if_id_flush    (if_id_flush),
    .id_ex_en       (id_ex_en),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_en      (ex_mem_en),
    .mem_wb_en      (mem_wb_en),
    .stall_cause    (stall_cause),
    .mc_timeout     (mc_timeout)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_mem (perf_stall_mem)
    , .perf_stall_mc  (perf_stall_mc)
    , .perf_stall_lu  (perf_stall_lu)
    , .perf_flush     (perf_flush)
`endif
  );

  function automatic bit lu_rule();
    return ex_valid && ex_is_load && (ex_rd != 0) &&
           ((id_rs1_used && id_rs1_addr == ex_rd) || (id_rs2_used && id_rs2_addr == ex_rd));
  endfunction

  function automatic bit mc_rule();
    if (mc_age > 0) return !mc_done && (mc_age < TO);
    return ex_valid && ex_mc_req && !mc_done;
  endfunction

  function automatic int kind_now();
    if (!rst_n) return K_RESET;
    if (mem_req && !mem_ready) return K_MEM;
    if (mc_rule()) return K_MC;
    if (redirect_valid || pend) return K_REDIR;
    if (lu_rule()) return K_LU;
    return K_NONE;
  endfunction

  // {pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem, mem_wb, cause[2:0], timeout}
  function automatic logic [10:0] expected_vec(input int k);
    logic [6:0] en;
    logic [2:0] cause;
    case (k)
      K_MEM:   begin en = 7'b0000000; cause = 3'b100; end
      K_MC:    begin en = 7'b0000001; cause = 3'b010; end
      K_REDIR: begin en = 7'b1111111; cause = 3'b000; end
      K_LU:    begin en = 7'b0001111; cause = 3'b001; end
      default: begin en = 7'b1101011; cause = 3'b000; end
    endcase
    return {en, cause, tflag};
  endfunction

  task automatic model_advance();
    int k;
    bit mc_cont;
    k = kind_now();
    if (!rst_n) return;
    mc_cont = (mc_age > 0) && !mc_done && (mc_age < TO);
    if ((mc_age > 0) && !mc_done && (mc_age == TO)) tflag = 1;
    if (k == K_MEM || k == K_MC) begin
      if (redirect_valid) pend = 1;
    end else begin
      pend = 0;
    end
    if (k == K_MEM)      mc_age = mc_cont ? mc_age + 1 : 0;
    else if (k == K_MC)  mc_age = mc_age + 1;
    else                 mc_age = 0;
    if (k == K_MEM)   cnt_mem++;
    if (k == K_MC)    cnt_mc++;
    if (k == K_LU)    cnt_lu++;
    if (k == K_REDIR) cnt_fl++;
  endtask

  task automatic clear_inputs();
    id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_used = 0; id_rs2_used = 0;
    ex_valid = 0; ex_is_load = 0; ex_rd = '0; ex_mc_req = 0; mc_done = 0;
    mem_req = 0; mem_ready = 0; redirect_valid = 0;
  endtask

  task automatic enter_reset();
    rst_n = 0;
    mc_age = 0; pend = 0; tflag = 0;
    cnt_mem = 0; cnt_mc = 0; cnt_lu = 0; cnt_fl = 0;
  endtask

  task automatic apply_stimulus();
    id_rs1_addr    = AW'($urandom_range(0, 3));
    id_rs2_addr    = AW'($urandom_range(0, 3));
    ex_rd          = AW'($urandom_range(0, 3));
    id_rs1_used    = 1'($urandom_range(0, 1));
    id_rs2_used    = 1'($urandom_range(0, 1));
    ex_valid       = ($urandom_range(0, 3) != 0);
    ex_is_load     = ($urandom_range(0, 2) == 0);
    ex_mc_req      = ($urandom_range(0, 5) == 0);
    mc_done        = ($urandom_range(0, 4) == 0);
    mem_req        = ($urandom_range(0, 3) == 0);
    mem_ready      = 1'($urandom_range(0, 1));
    redirect_valid = ($urandom_range(0, 7) == 0);
  endtask

  // Compare at the falling edge, then advance the model through the rising edge
  task automatic check_output(input string tag);
    logic [10:0] got, exp;
    @(negedge clk);
    exp = expected_vec(kind_now());
    got = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en,
           stall_cause, mc_timeout};
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s ctrl got=%b exp=%b", tag, got, exp);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    assert ({perf_stall_mem, perf_stall_mc, perf_stall_lu, perf_flush} ===
            {PW'(cnt_mem), PW'(cnt_mc), PW'(cnt_lu), PW'(cnt_fl)}) else begin
      failures++;
      $error("[TB] FAIL %s perf got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", tag,
             perf_stall_mem, perf_stall_mc, perf_stall_lu, perf_flush,
             cnt_mem, cnt_mc, cnt_lu, cnt_fl);
    end
`endif
    model_advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    enter_reset();
    check_output("reset");
    check_output("reset_hold");
    rst_n = 1;
    check_output("idle");

    // load-use: lw x5 in EX, add x6,x5,x1 in ID
    ex_valid = 1; ex_is_load = 1; ex_rd = 5;
    id_rs1_used = 1; id_rs1_addr = 5; id_rs2_used = 1; id_rs2_addr = 1;
    check_output("lu_bubble");
    ex_valid = 0;
    check_output("lu_after");
    ex_valid = 1; ex_rd = 0; id_rs1_addr = 0;
    check_output("lu_x0");
    id_rs2_addr = 5; ex_rd = 5; id_rs1_used = 0;
    check_output("lu_rs2");
    clear_inputs();

    // multi-cycle op done after 10 stall cycles
    ex_valid = 1; ex_mc_req = 1;
    for (int i = 0; i < 10; i++) check_output("mc_stall");
    mc_done = 1;
    check_output("mc_release");
    clear_inputs();
    check_output("mc_idle");

    // memory wait of 4 cycles with redirects arriving mid-stall
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      redirect_valid = (i == 1) || (i == 2);
      check_output("mem_wait");
    end
    redirect_valid = 0; mem_ready = 1;
    check_output("mem_release_flush");
    clear_inputs();
    check_output("mem_no_flush");

    // memory stall and load-use together
    mem_req = 1; ex_valid = 1; ex_is_load = 1; ex_rd = 7; id_rs1_used = 1; id_rs1_addr = 7;
    check_output("prio_mem_lu");
    mem_ready = 1;
    check_output("prio_lu_after_mem");
    clear_inputs();

    // redirect and load-use together
    ex_valid = 1; ex_is_load = 1; ex_rd = 3; id_rs2_used = 1; id_rs2_addr = 3; redirect_valid = 1;
    check_output("prio_redir_lu");
    clear_inputs();

    // watchdog: mc_done never arrives
    ex_valid = 1; ex_mc_req = 1;
    for (int i = 0; i <= TO; i++) check_output("mc_timeout_run");
    clear_inputs();
    for (int i = 0; i < 3; i++) check_output("mc_timeout_sticky");

    // reset in the middle of a stall with a redirect pending
    ex_valid = 1; ex_mc_req = 1;
    check_output("rst_mid_stall");
    redirect_valid = 1;
    check_output("rst_mid_redir");
    redirect_valid = 0;
    #2;
    enter_reset();
    check_output("rst_mid_in_reset");
    rst_n = 1;
    clear_inputs();
    check_output("rst_mid_no_flush");

    // random traffic
    for (int i = 0; i < 500; i++) begin
      apply_stimulus();
      check_output("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
